// File: rtl/mem_access_unit.sv
// Load/store front end for data_memory: byte/half/word loads with extension,
// sub-word stores via two-cycle read-modify-write. Optional trap: LSU_MISALIGN_TRAP_EN.
module mem_access_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        misalign_err,
  output logic [31:0] mem_read_adr,
  output logic [31:0] mem_write_adr,
  output logic [31:0] mem_write_data,
  output logic        mem_memread,
  output logic        mem_memwrite,
  input  logic [31:0] mem_read_data
);

`ifdef LSU_MISALIGN_TRAP_EN
  typedef enum logic [1:0] {IDLE, LRESP, MERGE, ERR} state_t;
`else
  typedef enum logic [1:0] {IDLE, LRESP, MERGE} state_t;
`endif

  state_t      state, state_next;
  logic [31:0] merge_buf;
  logic [29:0] hold_idx;
  logic [1:0]  hold_lane;
  logic        hold_half;
  logic [15:0] hold_wdata;

  logic        is_byte, is_half, is_word, misalign, accept;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext, merged;

  // Request decode; with the trap disabled the low address bits are simply ignored
  always_comb begin
    is_byte = (req_size == 2'b00);
    is_half = (req_size == 2'b01);
`ifdef LSU_MISALIGN_TRAP_EN
    is_word  = (req_size == 2'b10);
    misalign = (req_size == 2'b11) || (is_half && req_addr[0]) ||
               (is_word && (req_addr[1:0] != 2'b00));
`else
    is_word  = req_size[1];
    misalign = 1'b0;
`endif
  end

  assign accept = (state == IDLE) && req_valid && !misalign;

  // Lane extraction and sign/zero extension of the combinational read data
  always_comb begin
    ld_byte = mem_read_data[{req_addr[1:0], 3'b000} +: 8];
    ld_half = req_addr[1] ? mem_read_data[31:16] : mem_read_data[15:0];
    ld_ext  = mem_read_data;
    if (is_byte)
      ld_ext = req_unsigned ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
    else if (is_half)
      ld_ext = req_unsigned ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
  end

  always_comb begin
    merged = merge_buf;
    if (hold_half)
      merged[{hold_lane[1], 4'b0000} +: 16] = hold_wdata;
    else
      merged[{hold_lane, 3'b000} +: 8] = hold_wdata[7:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (misalign) begin
`ifdef LSU_MISALIGN_TRAP_EN
            state_next = ERR;
`else
            state_next = IDLE;
`endif
          end else if (!req_write) begin
            state_next = LRESP;
          end else if (!is_word) begin
            state_next = MERGE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // All outputs are forced low while reset is held, including the strobes
  always_comb begin
    stall          = 1'b0;
    load_valid     = 1'b0;
    misalign_err   = 1'b0;
    mem_read_adr   = 32'h0;
    mem_write_adr  = 32'h0;
    mem_write_data = 32'h0;
    mem_memread    = 1'b0;
    mem_memwrite   = 1'b0;
    if (reset) begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (misalign) begin
              stall = 1'b1;
            end else if (req_write && is_word) begin
              mem_memwrite   = 1'b1;
              mem_write_data = req_wdata;
              mem_read_adr   = {2'b00, req_addr[31:2]};
              mem_write_adr  = {2'b00, req_addr[31:2]};
            end else begin
              mem_memread   = 1'b1;
              stall         = 1'b1;
              mem_read_adr  = {2'b00, req_addr[31:2]};
              mem_write_adr = {2'b00, req_addr[31:2]};
            end
          end
        end
        LRESP: load_valid = 1'b1;
        MERGE: begin
          mem_memwrite   = 1'b1;
          mem_write_data = merged;
          mem_read_adr   = {2'b00, hold_idx};
          mem_write_adr  = {2'b00, hold_idx};
        end
        default: misalign_err = 1'b1;
      endcase
    end
  end

  // Load result and RMW context captured at the accepting edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      load_data  <= 32'h0;
      merge_buf  <= 32'h0;
      hold_idx   <= 30'h0;
      hold_lane  <= 2'b00;
      hold_half  <= 1'b0;
      hold_wdata <= 16'h0;
    end else if (accept) begin
      if (!req_write) begin
        load_data <= ld_ext;
      end else if (!is_word) begin
        merge_buf  <= mem_read_data;
        hold_idx   <= req_addr[31:2];
        hold_lane  <= req_addr[1:0];
        hold_half  <= is_half;
        hold_wdata <= req_wdata[15:0];
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed test-plan cases plus random
// traffic against a transaction-level memory model. Honors LSU_MISALIGN_TRAP_EN.
module tb_mem_access_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_write, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        stall, load_valid, misalign_err, mem_memread, mem_memwrite;
  logic [31:0] load_data, mem_read_adr, mem_write_adr, mem_write_data, mem_read_data;

  mem_access_unit dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .stall(stall), .load_data(load_data),
    .load_valid(load_valid), .misalign_err(misalign_err),
    .mem_read_adr(mem_read_adr), .mem_write_adr(mem_write_adr),
    .mem_write_data(mem_write_data), .mem_memread(mem_memread),
    .mem_memwrite(mem_memwrite), .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  // Bench-side data_memory: combinational read, write at the rising edge
  logic [31:0] ram [256];
  logic        init_mem;
  assign mem_read_data = ram[mem_read_adr[7:0]];
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 256; i++) ram[i] <= 32'(i);
    end else if (mem_memwrite) begin
      ram[mem_write_adr[7:0]] <= mem_write_data;
    end
  end

  logic [31:0] ref_mem [256];
  int          n_checks = 0;
  int          n_pass   = 0;
  logic        chk_en   = 1'b0;
  logic        exp_stall, exp_lv, exp_err, exp_rd, exp_wr;
  logic [31:0] exp_adr, exp_wdata, exp_ld;
  logic [31:0] model_ld;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %08h want %08h at t=%0t", name, act, want, $time);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("stall", 32'(stall), 32'(exp_stall));
      chk("load_valid", 32'(load_valid), 32'(exp_lv));
      chk("misalign_err", 32'(misalign_err), 32'(exp_err));
      chk("memread", 32'(mem_memread), 32'(exp_rd));
      chk("memwrite", 32'(mem_memwrite), 32'(exp_wr));
      if (exp_rd || exp_wr) begin
        chk("read_adr", mem_read_adr, exp_adr);
        chk("write_adr", mem_write_adr, exp_adr);
      end
      if (exp_wr) chk("write_data", mem_write_data, exp_wdata);
      if (exp_lv) chk("load_data", load_data, exp_ld);
      if (!reset) begin
        chk("rst_read_adr", mem_read_adr, 32'h0);
        chk("rst_write_data", mem_write_data, 32'h0);
        chk("rst_load_data", load_data, 32'h0);
      end
    end
  end

  task automatic clear_exp();
    exp_stall = 0; exp_lv = 0; exp_err = 0; exp_rd = 0; exp_wr = 0;
    exp_adr = 0; exp_wdata = 0; exp_ld = 0;
  endtask

  function automatic logic is_misaligned(input logic [1:0] sz, input logic [31:0] a);
`ifdef LSU_MISALIGN_TRAP_EN
    return (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic int eff_bytes(input logic [1:0] sz);
    if (sz == 2'd0) return 1;
    if (sz == 2'd1) return 2;
    return 4;
  endfunction

  // Bit offset of the addressed lane inside its word
  function automatic int lane_shift(input int nb, input logic [31:0] a);
    if (nb == 1) return 8 * int'(a % 4);
    if (nb == 2) return 16 * int'((a / 2) % 2);
    return 0;
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      req_valid = 0;
      clear_exp();
      @(posedge clk); #1;
    end
  endtask

  // Drive one request and set per-cycle expectations from the model
  task automatic do_req(input logic w, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd);
    int nb, sh, idx;
    logic [31:0] mask, word;
    nb = eff_bytes(sz);
    sh = lane_shift(nb, a);
    idx = int'(a / 4) % 256;
    mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nb)) - 1);
    word = ref_mem[idx];
    req_valid = 1; req_write = w; req_size = sz; req_unsigned = uns;
    req_addr = a; req_wdata = wd;
    clear_exp();
    exp_adr = a / 4;
    if (is_misaligned(sz, a)) begin
      exp_stall = 1;
      @(posedge clk); #1;
      clear_exp(); exp_err = 1;
      @(posedge clk); #1;
    end else if (w && nb == 4) begin
      exp_wr = 1; exp_wdata = wd;
      @(posedge clk); #1;
      ref_mem[idx] = wd;
    end else if (!w) begin
      exp_stall = 1; exp_rd = 1;
      model_ld = (word >> sh) & mask;
      if (!uns && nb < 4 && model_ld[8 * nb - 1]) model_ld = model_ld | ~mask;
      @(posedge clk); #1;
      clear_exp(); exp_lv = 1; exp_ld = model_ld;
      @(posedge clk); #1;
    end else begin
      exp_stall = 1; exp_rd = 1;
      @(posedge clk); #1;
      clear_exp(); exp_wr = 1; exp_adr = a / 4;
      exp_wdata = (word & ~(mask << sh)) | ((wd & mask) << sh);
      @(posedge clk); #1;
      ref_mem[idx] = exp_wdata;
    end
    req_valid = 0;
    clear_exp();
  endtask

  task automatic load_lit(input string name, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] lit);
    do_req(0, sz, uns, a, 32'h0);
    chk({name, "_model"}, model_ld, lit);
    chk(name, load_data, lit);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'(i);
    reset = 0; init_mem = 1;
    req_valid = 1; req_write = 0; req_size = 2'd2; req_unsigned = 0;
    req_addr = 32'h14; req_wdata = 32'h0;
    clear_exp();
    model_ld = 0;
    #1 chk_en = 1;
    @(posedge clk); #1;
    init_mem = 0;
    @(posedge clk); #1;
    req_valid = 0;
    @(negedge clk); reset = 1;
    @(posedge clk); #1;

    load_lit("lw_0x14", 2'd2, 0, 32'h14, 32'h0000_0005);
    do_req(1, 2'd2, 0, 32'h20, 32'hDEAD_BEEF);
    load_lit("lw_0x20", 2'd2, 0, 32'h20, 32'hDEAD_BEEF);
    do_req(1, 2'd2, 0, 32'h30, 32'h8001_8283);
    load_lit("lb_0x33", 2'd0, 0, 32'h33, 32'hFFFF_FF80);
    load_lit("lbu_0x33", 2'd0, 1, 32'h33, 32'h0000_0080);
    load_lit("lh_0x32", 2'd1, 0, 32'h32, 32'hFFFF_8001);
    load_lit("lhu_0x30", 2'd1, 1, 32'h30, 32'h0000_8283);
    do_req(1, 2'd0, 0, 32'h41, 32'h0000_00AB);
    load_lit("lw_0x40_sb", 2'd2, 0, 32'h40, 32'h0000_AB10);
    do_req(1, 2'd1, 0, 32'h42, 32'h0000_1234);
    load_lit("lw_0x40_sh", 2'd2, 0, 32'h40, 32'h1234_AB10);
    idle(1);
`ifdef LSU_MISALIGN_TRAP_EN
    do_req(0, 2'd1, 0, 32'h05, 32'h0);
    do_req(1, 2'd3, 0, 32'h08, 32'h5555_5555);
`else
    load_lit("lh_0x05", 2'd1, 0, 32'h05, 32'h0000_0001);
    do_req(1, 2'd3, 0, 32'h0B, 32'h5555_5555);
    load_lit("lw_0x08_sz3", 2'd2, 0, 32'h08, 32'h5555_5555);
`endif

    // Reset pulled low while the sub-word store sits in MERGE
    req_valid = 1; req_write = 1; req_size = 2'd0; req_unsigned = 0;
    req_addr = 32'h50; req_wdata = 32'h0000_00CC;
    clear_exp(); exp_stall = 1; exp_rd = 1; exp_adr = 32'h14;
    @(posedge clk); #1;
    reset = 0;
    clear_exp();
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rmw_reset_mem", ram[8'h14], 32'h0000_0014);
    req_valid = 0;
    @(negedge clk); reset = 1;
    @(posedge clk); #1;
    load_lit("lw_0x50_after_rst", 2'd2, 0, 32'h50, 32'h0000_0014);

    for (int t = 0; t < 300; t++) begin
      logic [1:0] sz;
      sz = 2'($urandom_range(0, 3));
      do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
             32'($urandom_range(0, 1023)), $urandom);
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
    end
    for (int i = 0; i < 256; i++) chk("final_mem", ram[i], ref_mem[i]);

    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
